// File: rtl/maf_pkg.sv
// Shared sizing and per-channel state record for the moving-average scheduler.
// Everything downstream derives its widths from these few constants.
package maf_pkg;

  localparam int NCH = 4;
  localparam int WIN = 4;
  localparam int DW  = 5;
  localparam int OW  = 8;

  localparam int CHW = $clog2(NCH);
  localparam int SW  = DW + $clog2(WIN);
  localparam int CW  = $clog2(WIN) + 1;

  // hist[0] is the newest sample, hist[WIN-1] the one about to leave the window
  typedef struct packed {
    logic [WIN-1:0][DW-1:0] hist;
    logic [SW-1:0]          sum;
    logic [CW-1:0]          cnt;
  } chState_t;

endpackage

// File: rtl/maf_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester
// found by searching upward from ptr_i, wrapping around (N is a power of two).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         mask_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o
);

  localparam int PW = $clog2(N);

  logic [N-1:0]  eligible;
  logic [PW-1:0] idx;
  logic          found;

  assign eligible = req_i & ~mask_i;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_i + PW'(i);
      if (!found && eligible[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maf_sched.sv
// Four-channel time-multiplexed moving-average filter: one shared
// sliding-window add/subtract datapath, round-robin access, registered result.
module maf_sched
  import maf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH-1:0]    clr,
  output logic [NCH-1:0]    gnt,
  output logic              dout_valid,
  output logic [CHW-1:0]    dout_ch,
  output logic [OW-1:0]     dout,
  output logic              dout_full
);

  chState_t       chState_q [NCH];
  logic [CHW-1:0] ptr_q;
  logic           doutValid_q;
  logic [CHW-1:0] doutCh_q;
  logic [OW-1:0]  dout_q;
  logic           doutFull_q;

  logic           accept;
  logic [CHW-1:0] gntIdx;
  logic [DW-1:0]  sample;
  chState_t       granted;
  chState_t       grantState_d;

  // Clearing channels are masked so a clear always wins over a pending sample
  rr_arbiter #(.N(NCH)) uArb (
    .req_i  (req),
    .mask_i (clr),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt)
  );

  // Next state of the granted channel; the dropped sample is already inside
  // the sum, so the subtract never underflows and the sum never wraps.
  always_comb begin
    gntIdx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) gntIdx = CHW'(k);
    end
    accept  = |gnt;
    sample  = din[gntIdx*DW +: DW];
    granted = chState_q[gntIdx];
    grantState_d.hist = {granted.hist[WIN-2:0], sample};
    grantState_d.sum  = granted.sum - SW'(granted.hist[WIN-1]) + SW'(sample);
    grantState_d.cnt  = (granted.cnt == CW'(WIN)) ? granted.cnt
                                                  : granted.cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) chState_q[k] <= '0;
      ptr_q       <= '0;
      doutValid_q <= 1'b0;
      doutCh_q    <= '0;
      dout_q      <= '0;
      doutFull_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (clr[k]) begin
          chState_q[k] <= '0;
        end else if (accept && (gntIdx == CHW'(k))) begin
          chState_q[k] <= grantState_d;
        end
      end
      doutValid_q <= accept;
      if (accept) begin
        ptr_q      <= gntIdx + CHW'(1);
        doutCh_q   <= gntIdx;
        dout_q     <= OW'(grantState_d.sum);
        doutFull_q <= (grantState_d.cnt == CW'(WIN));
      end
    end
  end

  assign dout_valid = doutValid_q;
  assign dout_ch    = doutCh_q;
  assign dout       = dout_q;
  assign dout_full  = doutFull_q;

endmodule

// File: doc/maf_sched.md
# maf_sched

Four-channel time-multiplexed moving-average filter controller. It shares one sliding-window accumulate/subtract datapath between NCH sample requesters. A round-robin arbiter grants one requester per cycle, and per-channel history and running sums are stored internally. Each accepted sample produces one registered average-sum result tagged with its channel. It sits between the ADC/sample front-ends and the downstream display/threshold logic.

## Interface
- NCH, 4: number of channels; power of two, 2..8.
- WIN, 4: window length in samples; power of two, 2..8.
- DW, 5: input sample width.
- OW, 8: output sum width; must satisfy OW ≥ DW + log2(WIN).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NCH  per-channel sample request; held high until granted.
- din  in  NCH*DW  channel k sample on din[k*DW +: DW]; stable while req[k] is high.
- clr  in  NCH  per-channel synchronous clear of history, sum and fill count.
- gnt  out  NCH  one-hot grant, combinational from req, clr and pointer; zero when idle.
- dout_valid  out  1  registered; high for one cycle per accepted sample.
- dout_ch  out  log2(NCH)  channel of current dout.
- dout  out  OW  window sum for dout_ch, zero-extended.
- dout_full  out  1  channel dout_ch had ≥ WIN accepted samples, including this one.

## Operation
- Eligibility: req[k] & ~clr[k].
- Arbiter: round-robin search starting at ptr, wrapping modulo NCH. gnt is the first eligible channel.
- Acceptance happens at a clock edge with gnt[k]=1. At that edge:
  - sum[k] <= sum[k] − hist[k][oldest] + din_k
  - hist[k] shifts, inserting din_k and dropping the oldest entry
  - cnt[k] <= min(cnt[k]+1, WIN)
  - ptr <= (k+1) mod NCH
- With no grant, ptr holds.
- Output registers load on acceptance: dout=new sum[k], dout_ch=k, dout_full=(new cnt[k]==WIN), dout_valid=1. Without acceptance, dout_valid=0 and the other outputs hold their values.
- Arithmetic: sum is unsigned with width DW+log2(WIN). It never overflows, because the subtracted value is always part of the sum. Maximum sum with defaults: 4×31=124.
- clr[k]:
  - Zeroes hist[k], sum[k] and cnt[k] at the next edge.
  - Channel k is not granted that cycle. A held req[k] is granted later.
  - Other channels are unaffected.
  - If clr[k] is asserted while dout_ch==k, the held dout does not change.
- Back-to-back grants to the same channel (NCH=1 eligible) are legal every cycle. No hazard exists because the update is single-edge.
- Before a channel is full, empty history slots read 0, so the sum is a partial sum.

## Timing
- Reset values: gnt=0 (req is masked only by logic; gnt follows inputs combinationally), dout_valid=0, dout=0, dout_ch=0, dout_full=0, ptr=0, all hist/sum/cnt=0.
- Requester handshake: the sample is taken at the edge where req[k]&gnt[k]. The requester drops req or presents the next sample in the following cycle.
- Latency: result appears 1 cycle after the acceptance edge. Throughput is 1 sample/cycle aggregate.
- Fairness: a continuously requesting channel waits at most NCH−1 cycles.
- Reset asserted mid-operation clears everything immediately and asynchronously. Samples held on req are re-granted after release, starting from channel 0.

## Structure
- Package maf_pkg holds:
  - NCH, WIN, DW and OW defaults
  - derived widths CHW=log2(NCH), SW=DW+log2(WIN), CW=log2(WIN)+1
  - a typedef for the per-channel state record (hist, sum, cnt)
- Sub-module rr_arbiter (NCH-wide, combinational grant from req, mask and ptr) is instantiated once. The rest, datapath and state array, lives in maf_sched.

## Test plan
- Ch0 only, samples 1,2,3,4,5 on consecutive cycles:
  - dout = 1, 3, 6, 10, 14
  - dout_full = 0, 0, 0, 1, 1
  - dout_ch=0, one result per cycle
- All four req high from reset, held continuously: grants cycle 0,1,2,3,0. Each dout_ch matches the grant one cycle earlier.
- Ch1 fed 31 eight times: dout climbs 31, 62, 93, 124, then holds 124. Sum width never wraps.
- Ch2 has 3 samples of 7 (sum 21); clr[2] asserted while req[2] high:
  - no gnt[2] that cycle
  - next grant with din=5 gives dout=5, dout_full=0
  - ch3 sums are unaffected
- Reset asserted asynchronously between edges during traffic: outputs go to 0 immediately. After release, the first grant goes to the lowest requesting channel and all sums restart from 0.
- Interleaved ch0/ch3 requests with gaps: ptr advances only on grants, and dout_valid is low during idle cycles.
